// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the prefetching instruction fetch queue.
package instr_fetch_queue_pkg;

  localparam int PC_W         = 9;
  localparam int INS_W        = 32;
  localparam int FETCH_STRIDE = 4;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is visible combinationally.
module instr_fetch_queue_sync_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch stage: owns the fetch PC, issues imem requests under a credit rule,
// tags returning words with their PC and queues them for decode; redirects flush wrong-path work.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic             id_valid_o,
  output logic [PC_W-1:0]  id_pc_o,
  output logic [INS_W-1:0] id_instr_o,
  input  logic             id_stall_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [PC_W-1:0] target_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   outst_next;
  logic [OW-1:0]   drop;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            credit_ok;
  logic            transfer;
  logic            accept;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  fetch_entry_t    last;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // Dropped-but-outstanding requests still occupy credits until their response returns.
  assign credit_ok   = (int'(count) + int'(outst) < DEPTH) && (int'(outst) < MAX_OUTST);
  assign imem_req_o  = reset && credit_ok;
  assign imem_addr_o = fetch_pc;
  assign transfer    = imem_req_o && imem_gnt_i;
  assign accept      = imem_rvalid_i && (drop == '0);
  assign push        = accept && !redirect_i;
  assign pop         = id_valid_o && !id_stall_i && !redirect_i;
  assign target_pc   = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign outst_next  = outst + OW'(transfer) - OW'(imem_rvalid_i);

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rdata_i;

  instr_fetch_queue_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .din   (push_entry),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Decode sees the FIFO head; when empty it keeps showing the last instruction consumed.
  assign id_valid_o = !empty;
  assign id_pc_o    = empty ? last.pc    : head.pc;
  assign id_instr_o = empty ? last.instr : head.instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
      last     <= '0;
    end else begin
      outst <= outst_next;
      if (redirect_i) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop     <= outst_next;
      end else begin
        if (transfer) fetch_pc <= fetch_pc + PC_W'(FETCH_STRIDE);
        if (accept)   rsp_pc   <= rsp_pc + PC_W'(FETCH_STRIDE);
        if (imem_rvalid_i && (drop != '0)) drop <= drop - OW'(1);
        if (pop) last <= head;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid_i |-> (outst != '0));
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (imem_req_o && !imem_gnt_i && !redirect_i) |=> $stable(imem_addr_o));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: imem model with in-order responses, scoreboard of expected decode entries.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             redirect_i = 1'b0;
  logic [PC_W-1:0]  redirect_pc_i = '0;
  logic             imem_req_o;
  logic [PC_W-1:0]  imem_addr_o;
  logic             imem_gnt_i = 1'b0;
  logic             imem_rvalid_i = 1'b0;
  logic [INS_W-1:0] imem_rdata_i = '0;
  logic             id_valid_o;
  logic [PC_W-1:0]  id_pc_o;
  logic [INS_W-1:0] id_instr_o;
  logic             id_stall_i = 1'b0;

  int checks = 0;
  int errors = 0;
  bit rsp_en = 1'b1;

  typedef struct {
    logic [PC_W-1:0] addr;
    bit              wrong;
  } pend_t;

  pend_t           pend[$];
  logic [PC_W-1:0] sb[$];
  logic [PC_W-1:0] model_pc = '0;

  bit              s_rst, s_fire, s_rv, s_redir, s_pop;
  logic [PC_W-1:0] s_addr, s_target;
  pend_t           r;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  ('0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .id_stall_i    (id_stall_i)
  );

  function automatic logic [INS_W-1:0] mem_data(input logic [PC_W-1:0] a);
    return 32'hC0DE_0000 ^ {a, 23'h0} ^ {23'h0, a};
  endfunction

  function automatic bit exp_req();
    return (sb.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUTST);
  endfunction

  // imem model + decode monitor: sample mid-low-phase, update just after the edge.
  initial forever begin
    @(negedge clk);
    #2;
    s_rst    = reset;
    s_fire   = imem_req_o && imem_gnt_i;
    s_addr   = imem_addr_o;
    s_rv     = imem_rvalid_i;
    s_redir  = redirect_i;
    s_target = redirect_pc_i & ~PC_W'(3);
    s_pop    = reset && id_valid_o && !id_stall_i && !redirect_i;
    if (s_fire) begin
      checks++;
      if (imem_addr_o !== model_pc) begin
        errors++;
        $display("FAIL fetch_addr: got %h expected %h", imem_addr_o, model_pc);
      end
    end
    if (s_pop) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL id_pop_unexpected: got pc=%h with no entry expected", id_pc_o);
      end else if (id_pc_o !== sb[0] || id_instr_o !== mem_data(sb[0])) begin
        errors++;
        $display("FAIL id_pop: got pc=%h instr=%h expected pc=%h instr=%h",
                 id_pc_o, id_instr_o, sb[0], mem_data(sb[0]));
      end else begin
        $display("id pop pc=%h instr=%h", id_pc_o, id_instr_o);
      end
    end
    @(posedge clk);
    #1;
    if (!s_rst) begin
      pend.delete();
      sb.delete();
      model_pc = '0;
    end else begin
      if (s_pop && sb.size() > 0) void'(sb.pop_front());
      if (s_rv && pend.size() > 0) begin
        r = pend.pop_front();
        if (!r.wrong && !s_redir) sb.push_back(r.addr);
      end
      if (s_fire) begin
        pend.push_back('{s_addr, 1'b0});
        model_pc = model_pc + PC_W'(FETCH_STRIDE);
      end
      if (s_redir) begin
        foreach (pend[i]) pend[i].wrong = 1'b1;
        sb.delete();
        model_pc = s_target;
      end
    end
    if (reset && rsp_en && pend.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL %s_req: got %b expected 0", tag, imem_req_o); end
    checks++;
    if (imem_addr_o !== '0) begin errors++; $display("FAIL %s_addr: got %h expected 000", tag, imem_addr_o); end
    checks++;
    if (id_valid_o !== 1'b0) begin errors++; $display("FAIL %s_id_valid: got %b expected 0", tag, id_valid_o); end
    checks++;
    if (id_pc_o !== '0) begin errors++; $display("FAIL %s_id_pc: got %h expected 000", tag, id_pc_o); end
    checks++;
    if (id_instr_o !== '0) begin errors++; $display("FAIL %s_id_instr: got %h expected 0", tag, id_instr_o); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] exp_addr = '0;
    logic [PC_W-1:0] exp_id = '0;
    imem_gnt_i = 1'b1;
    rsp_en = 1'b1;
    id_stall_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr) begin
        errors++;
        $display("FAIL stream_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, exp_addr);
      end
      exp_addr = exp_addr + PC_W'(4);
      if (i >= 2) begin
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== exp_id) begin
          errors++;
          $display("FAIL stream_id: got valid=%b pc=%h expected valid=1 pc=%h", id_valid_o, id_pc_o, exp_id);
        end
        exp_id = exp_id + PC_W'(4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    id_stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_o !== exp_req()) begin
        errors++;
        $display("FAIL stall_req: got %b expected %b", imem_req_o, exp_req());
      end
      checks++;
      if (sb.size() == 0 || id_valid_o !== 1'b1 || id_pc_o !== sb[0]) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b pc=%h expected valid=1 pc=%h", id_valid_o, id_pc_o,
                 (sb.size() > 0) ? sb[0] : PC_W'(0));
      end
    end
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_full_req: got %b expected 0", imem_req_o);
    end
    id_stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_o !== exp_req()) begin
        errors++;
        $display("FAIL resume_req: got %b expected %b", imem_req_o, exp_req());
      end
    end
  endtask

  task automatic test_gnt_low();
    logic [PC_W-1:0] held;
    imem_gnt_i = 1'b0;
    held = model_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== held) begin
        errors++;
        $display("FAIL gnt_low_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, held);
      end
    end
    imem_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_addr_o !== held + PC_W'(4)) begin
      errors++;
      $display("FAIL gnt_resume_addr: got %h expected %h", imem_addr_o, held + PC_W'(4));
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    imem_gnt_i = 1'b0;
    id_stall_i = 1'b0;
    rsp_en = 1'b1;
    repeat (8) @(negedge clk);
    id_stall_i = 1'b1;
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    rsp_en = 1'b0;
    imem_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || id_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL redir_setup: got req=%b valid=%b expected req=1 valid=1", imem_req_o, id_valid_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = PC_W'(9'h103);
    @(negedge clk);
    redirect_i = 1'b0;
    id_stall_i = 1'b0;
    rsp_en = 1'b1;
    checks++;
    if (id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_valid: got %b expected 0", id_valid_o);
    end
    checks++;
    if (imem_addr_o !== PC_W'(9'h100)) begin
      errors++;
      $display("FAIL redir_addr: got %h expected 100", imem_addr_o);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (id_valid_o === 1'b1) begin
        found = 1'b1;
        checks++;
        if (id_pc_o !== PC_W'(9'h100) || id_instr_o !== mem_data(PC_W'(9'h100))) begin
          errors++;
          $display("FAIL redir_first: got pc=%h instr=%h expected pc=100 instr=%h",
                   id_pc_o, id_instr_o, mem_data(PC_W'(9'h100)));
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL redir_timeout: got no id_valid expected pc=100");
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_a  = PC_W'(9'h1F8);
    logic [PC_W-1:0] exp_id = PC_W'(9'h1F8);
    int n_a = 0;
    int n_id = 0;
    imem_gnt_i = 1'b1;
    id_stall_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = PC_W'(9'h1F8);
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 30 && (n_a < 4 || n_id < 4); i++) begin
      if (n_a < 4 && imem_req_o === 1'b1) begin
        checks++;
        if (imem_addr_o !== exp_a) begin
          errors++;
          $display("FAIL wrap_addr: got %h expected %h", imem_addr_o, exp_a);
        end
        exp_a = exp_a + PC_W'(4);
        n_a++;
      end
      if (n_id < 4 && id_valid_o === 1'b1) begin
        checks++;
        if (id_pc_o !== exp_id) begin
          errors++;
          $display("FAIL wrap_id_pc: got %h expected %h", id_pc_o, exp_id);
        end
        exp_id = exp_id + PC_W'(4);
        n_id++;
      end
      @(negedge clk);
    end
    if (n_a < 4 || n_id < 4) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got %0d addrs %0d ids expected 4 and 4", n_a, n_id);
    end
  endtask

  task automatic test_reset_midstream();
    bit found = 1'b0;
    id_stall_i = 1'b1;
    imem_gnt_i = 1'b1;
    rsp_en = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_full: got valid=%b req=%b expected valid=1 req=0", id_valid_o, imem_req_o);
    end
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    id_stall_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (id_valid_o === 1'b1) begin
        found = 1'b1;
        checks++;
        if (id_pc_o !== '0 || id_instr_o !== mem_data('0)) begin
          errors++;
          $display("FAIL midreset_refetch: got pc=%h instr=%h expected pc=000 instr=%h",
                   id_pc_o, id_instr_o, mem_data('0));
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL midreset_timeout: got no id_valid expected pc=000");
    end
    repeat (6) @(negedge clk);
    imem_gnt_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
